// File: rtl/serial_logic_unit.sv
// Nibble-serial bitwise logic unit: one 4-bit slice per clock, LSB nibble first.
// Optional upper op codes (NAND/NOR/XNOR) enabled by defining SERIAL_LOGIC_EXT_OPS_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// RUN    | one slice computed per edge, counter 0 .. WIDTH/4-1
// DONE   | out holds the new result; done pulses for this one cycle
module serial_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;

    logic [CW+1:0]    w_sel;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_a_sl;
    logic [3:0]       w_b_sl;
    logic [3:0]       w_slice;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    assign w_sel  = {r_cnt, 2'b00};
    assign w_a_sh = r_a >> w_sel;
    assign w_b_sh = r_b >> w_sel;
    assign w_a_sl = w_a_sh[3:0];
    assign w_b_sl = w_b_sh[3:0];
    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_slice = w_a_sl;
        case (r_op)
            3'd0: w_slice = ~w_a_sl;
            3'd1: w_slice = w_a_sl & w_b_sl;
            3'd2: w_slice = w_a_sl | w_b_sl;
            3'd3: w_slice = w_a_sl ^ w_b_sl;
`ifdef SERIAL_LOGIC_EXT_OPS_EN
            3'd4: w_slice = ~(w_a_sl & w_b_sl);
            3'd5: w_slice = ~(w_a_sl | w_b_sl);
            3'd6: w_slice = ~(w_a_sl ^ w_b_sl);
            default: w_slice = w_a_sl;
`else
            default: w_slice = w_a_sl;
`endif
        endcase
    end

    // Merge the current slice into the result so the final edge can load out directly.
    assign w_res_next = (r_res & ~({{(WIDTH-4){1'b0}}, 4'hF} << w_sel))
                      | ({{(WIDTH-4){1'b0}}, w_slice} << w_sel);

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_res <= w_res_next;
                    // Counter parks on the last slice instead of wrapping.
                    if (w_last) r_out <= w_res_next;
                    else        r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and checks whenever done is seen.
module tb_serial_logic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, busy, done;
    logic [31:0] out;

    serial_logic_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: result/latency on done, ready after done, out stability otherwise.
    logic [31:0] prev_out = '0;
    logic        rst_prev = 1'b1;
    logic        want_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (want_ready) begin
            chk("ready_after_done", {31'd0, ready}, 32'd1);
            want_ready = 1'b0;
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("out", out, e.res);
                chk("done_cycle", cyc, e.at);
                want_ready = 1'b1;
            end
        end else if (!rst_prev) begin
            chk("out_stable", out, prev_out);
        end
        prev_out = out;
        rst_prev = rst;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] res);
        exp_t e;
        wait_ready();
        start = 1'b1; op = o; a = va; b = vb;
        e.res = res;
        e.at  = cyc + 9;
        q.push_back(e);
        step();
        start = 1'b0;
    endtask

    logic [31:0] x_nand, x_nor, x_xnor;
    int c0;

    initial begin
`ifdef SERIAL_LOGIC_EXT_OPS_EN
        x_nand = 32'hEDCB_FFFF;
        x_nor  = 32'hFF00_0000;
        x_xnor = 32'hAAAA_AAAA;
`else
        x_nand = 32'hFFFF_0000;
        x_nor  = 32'h0000_FFFF;
        x_xnor = 32'hAAAA_AAAA;
`endif
        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_out",   out,            32'd0);

        // First start lands on the first edge with rst low.
        rst = 1'b0;
        issue(3'd0, 32'h0F0F_1234, 32'h0, 32'hF0F0_EDCB);

        issue(3'd1, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000);
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            step();
        end

        // Start held high: one op per 10 cycles, DONE-cycle start ignored.
        wait_ready();
        start = 1'b1; op = 3'd3; a = 32'hAAAA_AAAA; b = 32'hFFFF_FFFF;
        c0 = cyc;
        for (int i = 0; i < 3; i++) q.push_back('{res: 32'h5555_5555, at: c0 + 9 + 10*i});
        repeat (25) step();
        start = 1'b0;

        // Abort with rst on the edge that would write slice 4.
        wait_ready();
        start = 1'b1; op = 3'd2; a = 32'h1111_0000; b = 32'h0000_2222;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out",   out,            32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_done",  {31'd0, done},  32'd0);
        repeat (12) step();
        issue(3'd2, 32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0);

        issue(3'd5, 32'h0000_FFFF, 32'h00FF_0000, x_nor);
        issue(3'd4, 32'hFFFF_0000, 32'h1234_5678, x_nand);
        issue(3'd6, 32'hAAAA_AAAA, 32'hFFFF_FFFF, x_xnor);
        issue(3'd7, 32'h0F0F_1234, 32'h5555_5555, 32'h0F0F_1234);

        for (int n = 0; n < 100 && q.size() != 0; n++) step();
        repeat (3) step();
        chk("pending_results", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
